// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART byte receiver: turns HEADER/addr/data/checksum
// frames into one register-write strobe, drives the LED bank and error status.
module uart_cmd_ctrl #(
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter logic [16:0] TIMEOUT  = 17'd65535,
    parameter logic [7:0]  LED_ADDR = 8'h00
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       reg_wr_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       busy,
    output logic       chk_err,
    output logic       to_err,
    output logic [7:0] err_cnt,
    output logic [7:0] led_out
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_WR   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [16:0] r_to_cnt;
    logic [16:0] w_to_cnt_nxt;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic        r_wr_en;
    logic [7:0]  r_reg_addr;
    logic [7:0]  r_reg_wdata;
    logic        r_busy;
    logic        r_chk_err;
    logic        r_to_err;
    logic [7:0]  r_err_cnt;
    logic [7:0]  r_led;

    logic        w_expired;
    logic        w_wr_go;
    logic        w_chk_bad;
    logic        w_to_fire;
    logic        w_cap_addr;
    logic        w_cap_data;

    // Modulo-256 frame checksum over header, address and data.
    function automatic logic [7:0] frame_sum(input logic [7:0] addr, input logic [7:0] data);
        return HEADER + addr + data;
    endfunction

    assign w_expired = (r_to_cnt == (TIMEOUT - 17'd1));

    // Next-state decode; an arriving byte always takes priority over expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_go     = 1'b0;
        w_chk_bad   = 1'b0;
        w_to_fire   = 1'b0;
        w_cap_addr  = 1'b0;
        w_cap_data  = 1'b0;
        case (r_state)
            S_HDR: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_HDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    w_cap_addr  = 1'b1;
                    w_state_nxt = S_DATA;
                end else if (w_expired) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    w_cap_data  = 1'b1;
                    w_state_nxt = S_CHK;
                end else if (w_expired) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == frame_sum(r_addr, r_data)) begin
                        w_wr_go     = 1'b1;
                        w_state_nxt = S_WR;
                    end else begin
                        w_chk_bad   = 1'b1;
                        w_state_nxt = S_HDR;
                    end
                end else if (w_expired) begin
                    w_to_fire   = 1'b1;
                    w_state_nxt = S_HDR;
                end else begin
                    w_state_nxt = S_CHK;
                end
            end
            S_WR: begin
                w_state_nxt = S_HDR;
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase
    end

    // Inter-byte timer runs only while waiting inside a frame.
    always_comb begin
        if (rx_valid || w_to_fire || (r_state == S_HDR) || (r_state == S_WR)) begin
            w_to_cnt_nxt = 17'd0;
        end else begin
            w_to_cnt_nxt = r_to_cnt + 17'd1;
        end
    end

    // State, capture registers and all registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_HDR;
            r_to_cnt    <= 17'd0;
            r_addr      <= 8'h00;
            r_data      <= 8'h00;
            r_wr_en     <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_busy      <= 1'b0;
            r_chk_err   <= 1'b0;
            r_to_err    <= 1'b0;
            r_err_cnt   <= 8'h00;
            r_led       <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_wr_en   <= w_wr_go;
            r_busy    <= (w_state_nxt != S_HDR);
            r_chk_err <= w_chk_bad;
            r_to_err  <= w_to_fire;
            if (w_cap_addr) begin
                r_addr <= rx_data;
            end
            if (w_cap_data) begin
                r_data <= rx_data;
            end
            if (w_wr_go) begin
                r_reg_addr  <= r_addr;
                r_reg_wdata <= r_data;
            end
            if ((w_chk_bad || w_to_fire) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            // LED bank follows the write one edge later, as S_WR is left.
            if ((r_state == S_WR) && (r_addr == LED_ADDR)) begin
                r_led <= r_data;
            end
        end
    end

    assign reg_wr_en = r_wr_en;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign busy      = r_busy;
    assign chk_err   = r_chk_err;
    assign to_err    = r_to_err;
    assign err_cnt   = r_err_cnt;
    assign led_out   = r_led;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames with cycle-exact checks, then a
// randomized byte stream scored against a frame-level model.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TO  = 20;

    logic       sys_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;
    logic       chk_err;
    logic       to_err;
    logic [7:0] err_cnt;
    logic [7:0] led_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] obs_q[$];
    int          n_chk_obs = 0;
    int          n_to_obs  = 0;

    logic [15:0] exp_q[$];
    int          m_pos;
    logic [7:0]  m_addr;
    logic [7:0]  m_data;
    int          m_err;
    int          m_chk;
    int          m_to;
    logic [7:0]  m_led;

    uart_cmd_ctrl #(
        .HEADER  (HDR),
        .TIMEOUT (17'd20),
        .LED_ADDR(8'h00)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .reg_wr_en(reg_wr_en),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .busy     (busy),
        .chk_err  (chk_err),
        .to_err   (to_err),
        .err_cnt  (err_cnt),
        .led_out  (led_out)
    );

    always #4 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (reg_wr_en) obs_q.push_back({reg_addr, reg_wdata});
            if (chk_err) n_chk_obs++;
            if (to_err) n_to_obs++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte strobed 'gap' clock edges after the previous one.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap - 1) @(negedge sys_clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(HDR, 3);
        send_byte(a, 3);
        send_byte(d, 3);
        send_byte(c, 3);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_wr"},   {31'd0, reg_wr_en}, 32'd0);
        check_val({tag, "_addr"}, {24'd0, reg_addr},  32'd0);
        check_val({tag, "_wd"},   {24'd0, reg_wdata}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, busy},      32'd0);
        check_val({tag, "_chk"},  {31'd0, chk_err},   32'd0);
        check_val({tag, "_to"},   {31'd0, to_err},    32'd0);
        check_val({tag, "_ecnt"}, {24'd0, err_cnt},   32'd0);
        check_val({tag, "_led"},  {24'd0, led_out},   32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pos = 0; m_addr = 8'h00; m_data = 8'h00;
        m_err = 0; m_chk = 0; m_to = 0; m_led = 8'h00;
    endtask

    task automatic model_timeout();
        m_to++;
        if (m_err < 255) m_err++;
        m_pos = 0;
    endtask

    // Frame-level reference: a mid-frame silence longer than TO edges aborts the frame.
    task automatic model_byte(input logic [7:0] b, input int gap);
        logic [7:0] sum;
        if ((m_pos > 0) && (gap > TO)) model_timeout();
        case (m_pos)
            0: m_pos = (b == HDR) ? 1 : 0;
            1: begin m_addr = b; m_pos = 2; end
            2: begin m_data = b; m_pos = 3; end
            default: begin
                sum = 8'((int'(HDR) + int'(m_addr) + int'(m_data)) % 256);
                if (b == sum) begin
                    exp_q.push_back({m_addr, m_data});
                    if (m_addr == 8'h00) m_led = m_data;
                end else begin
                    m_chk++;
                    if (m_err < 255) m_err++;
                end
                m_pos = 0;
            end
        endcase
    endtask

    function automatic int pick_gap();
        int r;
        r = $urandom_range(0, 19);
        if (r < 16) return $urandom_range(2, 12);
        else if (r < 18) return TO;
        else return TO + $urandom_range(1, 5);
    endfunction

    task automatic rand_send(input logic [7:0] b, input int gap);
        model_byte(b, gap);
        send_byte(b, gap);
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    initial begin
        int base_w, base_c, base_t, nw;
        logic [7:0] a, d, s;
        int kind, nb, g;

        rx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_all_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // LED-address write with exact one-cycle latency
        send_frame(8'h00, 8'h3C, 8'hE1);
        check_val("w1_en",   {31'd0, reg_wr_en}, 32'd1);
        check_val("w1_addr", {24'd0, reg_addr},  32'h00);
        check_val("w1_data", {24'd0, reg_wdata}, 32'h3C);
        check_val("w1_chk",  {31'd0, chk_err},   32'd0);
        @(negedge sys_clk);
        check_val("w1_en_off", {31'd0, reg_wr_en}, 32'd0);
        check_val("w1_led",    {24'd0, led_out},   32'h3C);
        check_val("w1_busy",   {31'd0, busy},      32'd0);

        send_frame(8'h07, 8'h10, 8'hBC);
        check_val("w2_en",   {31'd0, reg_wr_en}, 32'd1);
        check_val("w2_addr", {24'd0, reg_addr},  32'h07);
        check_val("w2_data", {24'd0, reg_wdata}, 32'h10);
        @(negedge sys_clk);
        check_val("w2_led",  {24'd0, led_out},   32'h3C);

        send_frame(8'h00, 8'h3C, 8'h00);
        check_val("bad_chk",  {31'd0, chk_err},   32'd1);
        check_val("bad_ecnt", {24'd0, err_cnt},   32'd1);
        check_val("bad_en",   {31'd0, reg_wr_en}, 32'd0);
        @(negedge sys_clk);
        check_val("bad_chk_off", {31'd0, chk_err}, 32'd0);
        check_val("bad_led",     {24'd0, led_out}, 32'h3C);

        send_byte(8'h11, 3);
        send_byte(8'h22, 3);
        send_frame(8'h00, 8'h55, 8'hFA);
        check_val("noise_en",   {31'd0, reg_wr_en}, 32'd1);
        check_val("noise_data", {24'd0, reg_wdata}, 32'h55);
        check_val("noise_ecnt", {24'd0, err_cnt},   32'd1);
        @(negedge sys_clk);
        check_val("noise_led",  {24'd0, led_out},   32'h55);

        // Silence after A5,00: to_err appears TO edges after the last byte
        send_byte(HDR, 3);
        send_byte(8'h00, 3);
        repeat (TO - 1) @(negedge sys_clk);
        check_val("to_early", {31'd0, to_err}, 32'd0);
        check_val("to_busy1", {31'd0, busy},   32'd1);
        @(negedge sys_clk);
        check_val("to_pulse", {31'd0, to_err},  32'd1);
        check_val("to_busy0", {31'd0, busy},    32'd0);
        check_val("to_ecnt",  {24'd0, err_cnt}, 32'd2);
        @(negedge sys_clk);
        check_val("to_off",   {31'd0, to_err},  32'd0);

        // Bytes landing exactly on the expiry cycle must win
        base_t = n_to_obs;
        send_byte(HDR, 3);
        send_byte(8'h00, 3);
        send_byte(8'h42, TO);
        send_byte(8'hE7, TO);
        check_val("exp_en",   {31'd0, reg_wr_en}, 32'd1);
        check_val("exp_data", {24'd0, reg_wdata}, 32'h42);
        repeat (3) @(negedge sys_clk);
        check_val("exp_no_to", n_to_obs - base_t, 32'd0);
        check_val("exp_ecnt",  {24'd0, err_cnt},  32'd2);
        check_val("exp_led",   {24'd0, led_out},  32'h42);

        // Asynchronous reset mid-frame clears everything at once
        send_byte(HDR, 3);
        send_byte(8'h00, 3);
        check_val("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        send_frame(8'h09, 8'h77, 8'h25);
        check_val("post_en",   {31'd0, reg_wr_en}, 32'd1);
        check_val("post_addr", {24'd0, reg_addr},  32'h09);
        check_val("post_data", {24'd0, reg_wdata}, 32'h77);
        check_val("post_ecnt", {24'd0, err_cnt},   32'd0);

        // Randomized stream against the frame-level model
        pulse_reset();
        model_reset();
        base_w = obs_q.size();
        base_c = n_chk_obs;
        base_t = n_to_obs;
        for (int it = 0; it < 80; it++) begin
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            d = 8'($urandom);
            s = 8'((int'(HDR) + int'(a) + int'(d)) % 256);
            if (kind <= 4) begin
                rand_send(HDR, pick_gap()); rand_send(a, pick_gap());
                rand_send(d, pick_gap());   rand_send(s, pick_gap());
            end else if (kind <= 6) begin
                rand_send(HDR, pick_gap()); rand_send(a, pick_gap());
                rand_send(d, pick_gap());
                rand_send(s ^ 8'($urandom_range(1, 255)), pick_gap());
            end else if (kind == 7) begin
                nb = $urandom_range(1, 2);
                for (int k = 0; k < nb; k++) rand_send(8'($urandom), pick_gap());
            end else begin
                nb = $urandom_range(0, 2);
                rand_send(HDR, pick_gap());
                if (nb > 0) rand_send(a, pick_gap());
                if (nb > 1) rand_send(d, pick_gap());
                g = TO + $urandom_range(1, 6);
                rand_send(8'($urandom), g);
            end
        end
        repeat (TO + 5) @(negedge sys_clk);
        if (m_pos > 0) model_timeout();
        nw = obs_q.size() - base_w;
        check_val("rnd_nwr", nw, exp_q.size());
        for (int k = 0; k < nw && k < exp_q.size(); k++)
            check_val($sformatf("rnd_wr%0d", k), {16'd0, obs_q[base_w + k]}, {16'd0, exp_q[k]});
        check_val("rnd_nchk", n_chk_obs - base_c, m_chk);
        check_val("rnd_nto",  n_to_obs - base_t,  m_to);
        check_val("rnd_ecnt", {24'd0, err_cnt},   m_err);
        check_val("rnd_led",  {24'd0, led_out},   {24'd0, m_led});
        check_val("rnd_busy", {31'd0, busy},      32'd0);

        // Error counter saturates instead of wrapping
        pulse_reset();
        for (int k = 0; k < 256; k++) begin
            send_byte(HDR, 2); send_byte(8'h01, 2);
            send_byte(8'h02, 2); send_byte(8'h00, 2);
        end
        @(negedge sys_clk);
        check_val("sat_ff", {24'd0, err_cnt}, 32'hFF);
        send_frame(8'h01, 8'h02, 8'h00);
        @(negedge sys_clk);
        check_val("sat_hold", {24'd0, err_cnt}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
